// File: rtl/aes_128_keyram_ctrl_pkg.sv
// Shared constants and FSM encodings for the AES-128 round-key RAM controller.
package aes_keyram_pkg;

    localparam int N_WORDS    = 22;
    localparam int N_ROUNDS   = 11;
    localparam int SW_TIMEOUT = 8;

    typedef enum logic [1:0] {
        L_IDLE,
        L_WRITE,
        L_FULL
    } l_state_e;

    typedef enum logic [1:0] {
        S_RUN,
        S_SWITCH,
        S_WAIT
    } s_state_e;

endpackage

// File: rtl/aes_128_keyram_ctrl_if.sv
// Loader, cipher-core and keyram signals of the round-key controller; master is the controller side.
interface aes_128_keyram_ctrl_if;

    logic        ld_valid;
    logic [63:0] ld_data;
    logic        ld_ready;
    logic        rk_req;
    logic        key_stall;
    logic        en_wr;
    logic [63:0] key_round_wr;
    logic        key_ready;
    logic        switch_key;
    logic        key_idx;

    modport master (
        input  ld_valid, ld_data, rk_req, key_idx,
        output ld_ready, key_stall, en_wr, key_round_wr, key_ready, switch_key
    );

    modport slave (
        output ld_valid, ld_data, rk_req, key_idx,
        input  ld_ready, key_stall, en_wr, key_round_wr, key_ready, switch_key
    );

endinterface

// File: rtl/aes_128_keyram_ctrl.sv
// Double-buffered AES-128 key-schedule controller: loads the shadow buffer, issues round keys
// from the active one, and swaps buffers only at a block boundary.
//
//   state    | meaning
//   L_IDLE   | no words of the next schedule written yet
//   L_WRITE  | partial schedule in the shadow buffer
//   L_FULL   | shadow buffer complete, loader held off until the swap lands
//   S_RUN    | rounds issued from the active buffer
//   S_SWITCH | swap pulse to the keyram, core stalled
//   S_WAIT   | waiting for key_idx to toggle, bounded by SW_TIMEOUT
module aes_128_keyram_ctrl #(
    parameter int N_WORDS    = aes_keyram_pkg::N_WORDS,
    parameter int N_ROUNDS   = aes_keyram_pkg::N_ROUNDS,
    parameter int SW_TIMEOUT = aes_keyram_pkg::SW_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  kill,
    aes_128_keyram_ctrl_if.master bus,
    output logic                  key_valid,
    output logic                  shadow_full,
    output logic                  sw_err
);
    import aes_keyram_pkg::*;

    localparam int RW = $clog2(N_ROUNDS);
    localparam int TW = $clog2(SW_TIMEOUT + 1);

    localparam logic [4:0]    WLAST = 5'(N_WORDS - 1);
    localparam logic [RW-1:0] RLAST = RW'(N_ROUNDS - 1);
    localparam logic [TW-1:0] TLAST = TW'(SW_TIMEOUT - 1);

    l_state_e      l_state;
    s_state_e      s_state;
    logic [4:0]    wcnt;
    logic [RW-1:0] rcnt;
    logic [TW-1:0] tmo;
    logic          idx_q;
    logic          en_wr_q;
    logic [63:0]   wr_data_q;
    logic          key_ready_q;
    logic          accept;
    logic          rk_acc;

    assign bus.ld_ready     = (l_state != L_FULL) && !kill;
    assign bus.key_stall    = (s_state != S_RUN);
    assign bus.switch_key   = (s_state == S_SWITCH);
    assign bus.en_wr        = en_wr_q;
    assign bus.key_round_wr = wr_data_q;
    assign bus.key_ready    = key_ready_q;

    assign accept = bus.ld_valid && bus.ld_ready;
    assign rk_acc = bus.rk_req && key_valid && !bus.key_stall;

    always_ff @(posedge clk) begin
        if (kill) begin
            l_state     <= L_IDLE;
            s_state     <= S_RUN;
            wcnt        <= '0;
            rcnt        <= '0;
            tmo         <= '0;
            idx_q       <= 1'b0;
            en_wr_q     <= 1'b0;
            wr_data_q   <= '0;
            key_ready_q <= 1'b0;
            key_valid   <= 1'b0;
            shadow_full <= 1'b0;
            sw_err      <= 1'b0;
        end else begin
            en_wr_q     <= accept;
            wr_data_q   <= accept ? bus.ld_data : '0;
            key_ready_q <= rk_acc;

            if (accept) begin
                if (wcnt == WLAST) begin
                    wcnt        <= '0;
                    l_state     <= L_FULL;
                    shadow_full <= 1'b1;
                end else begin
                    wcnt    <= wcnt + 5'd1;
                    l_state <= L_WRITE;
                end
            end

            if (rk_acc) begin
                rcnt <= (rcnt == RLAST) ? '0 : rcnt + RW'(1);
            end

            // A swap may only start between blocks; a request in the same cycle starts a block first.
            case (s_state)
                S_RUN: begin
                    if (shadow_full && (rcnt == '0) && !bus.rk_req) begin
                        s_state <= S_SWITCH;
                    end
                end
                S_SWITCH: begin
                    idx_q   <= bus.key_idx;
                    tmo     <= '0;
                    s_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.key_idx != idx_q) begin
                        s_state     <= S_RUN;
                        shadow_full <= 1'b0;
                        key_valid   <= 1'b1;
                        l_state     <= L_IDLE;
                    end else if (tmo == TLAST) begin
                        sw_err  <= 1'b1;
                        s_state <= S_RUN;
                    end else begin
                        tmo <= tmo + TW'(1);
                    end
                end
                default: s_state <= S_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_128_keyram_ctrl.sv
// Scoreboard bench for aes_128_keyram_ctrl with a behavioural loader, core and keyram.
module tb_aes_128_keyram_ctrl;

    localparam int N_WORDS    = 22;
    localparam int N_ROUNDS   = 11;
    localparam int SW_TIMEOUT = 8;

    logic clk  = 1'b0;
    logic kill = 1'b1;
    logic key_valid, shadow_full, sw_err;

    aes_128_keyram_ctrl_if bus ();

    aes_128_keyram_ctrl #(
        .N_WORDS   (N_WORDS),
        .N_ROUNDS  (N_ROUNDS),
        .SW_TIMEOUT(SW_TIMEOUT)
    ) dut (
        .clk        (clk),
        .kill       (kill),
        .bus        (bus),
        .key_valid  (key_valid),
        .shadow_full(shadow_full),
        .sw_err     (sw_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [63:0] data;
        bit          last;
    } wr_t;

    wr_t wq[$];
    int  kq[$];
    wr_t mon_e;
    int  mon_k;

    int cyc = 0;
    int n_checks = 0;
    int n_err = 0;
    int model_words = 0;
    int m_rcnt = 0;
    int n_switch = 0;
    int n_swap = 0;
    int n_kr = 0;
    bit model_full = 0;
    bit model_key_valid = 0;
    bit stuck = 0;
    bit expect_retry = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every DUT write / key_ready must match the oldest expected entry, one cycle after issue.
    always @(negedge clk) begin
        cyc++;
        if (bus.en_wr) begin
            if (wq.size() == 0) begin
                chk("unexpected_wr", 1, 0);
            end else begin
                mon_e = wq.pop_front();
                chk("wr_latency", cyc, mon_e.cyc + 1);
                chk("wr_data", bus.key_round_wr, mon_e.data);
                chk("shadow_full_at_wr", shadow_full, mon_e.last);
            end
        end else begin
            chk("wr_data_idle", bus.key_round_wr, 0);
            if (wq.size() > 0 && wq[0].cyc + 1 < cyc) begin
                chk("missing_wr", 0, 1);
                mon_e = wq.pop_front();
            end
        end
        if (bus.key_ready) begin
            n_kr++;
            if (kq.size() == 0) begin
                chk("unexpected_key_ready", 1, 0);
            end else begin
                mon_k = kq.pop_front();
                chk("key_ready_latency", cyc, mon_k + 1);
            end
        end else if (kq.size() > 0 && kq[0] + 1 < cyc) begin
            chk("missing_key_ready", 0, 1);
            mon_k = kq.pop_front();
        end
    end

    // Keyram model: toggles key_idx a few cycles after each swap pulse, or stays stuck once on request.
    initial begin
        bus.key_idx = 1'b0;
        forever begin
            @(negedge clk);
            if (expect_retry) begin
                chk("retry_switch", bus.switch_key, 1);
                expect_retry = 0;
            end
            if (bus.switch_key && !kill) begin
                n_switch++;
                chk("stall_in_switch", bus.key_stall, 1);
                chk("switch_at_block_end", m_rcnt, 0);
                chk("switch_needs_full", model_full, 1);
                if (stuck) begin
                    repeat (SW_TIMEOUT) @(negedge clk);
                    chk("sw_err_not_early", sw_err, 0);
                    chk("stall_in_wait", bus.key_stall, 1);
                    @(negedge clk);
                    chk("sw_err_timeout", sw_err, 1);
                    chk("stall_after_timeout", bus.key_stall, 0);
                    chk("shadow_kept", shadow_full, 1);
                    stuck = 0;
                    expect_retry = 1;
                end else begin
                    repeat ($urandom_range(1, 4)) @(negedge clk);
                    chk("stall_in_wait", bus.key_stall, 1);
                    bus.key_idx = ~bus.key_idx;
                    model_full = 0;
                    model_key_valid = 1;
                    @(negedge clk);
                    chk("shadow_cleared", shadow_full, 0);
                    chk("key_valid_set", key_valid, 1);
                    chk("stall_released", bus.key_stall, 0);
                    n_swap++;
                end
            end
        end
    end

    task automatic load_words(input int n, input logic [63:0] first, input bit rnd, input int gap_pct);
        int  i = 0;
        int  t = 0;
        wr_t w;
        while (i < n && t < 2000) begin
            @(negedge clk);
            t++;
            if ($urandom_range(0, 99) < gap_pct) begin
                bus.ld_valid = 1'b0;
                bus.ld_data  = '0;
            end else begin
                bus.ld_valid = 1'b1;
                bus.ld_data  = (i == 0 || !rnd) ? first + 64'(i) : {$urandom(), $urandom()};
                #1;
                chk("ld_ready", bus.ld_ready, !model_full);
                if (bus.ld_ready) begin
                    model_words++;
                    w.cyc  = cyc;
                    w.data = bus.ld_data;
                    w.last = (model_words == N_WORDS);
                    wq.push_back(w);
                    if (model_words == N_WORDS) begin
                        model_words = 0;
                        model_full  = 1;
                    end
                    i++;
                end
            end
        end
        chk("load_bound", i, n);
        @(negedge clk);
        bus.ld_valid = 1'b0;
        bus.ld_data  = '0;
    endtask

    task automatic rk_pulse();
        int t = 0;
        @(negedge clk);
        while (bus.key_stall && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("stall_bound", t < 50, 1);
        bus.rk_req = 1'b1;
        #1;
        if (model_key_valid) begin
            kq.push_back(cyc);
            m_rcnt = (m_rcnt + 1) % N_ROUNDS;
        end
        @(negedge clk);
        bus.rk_req = 1'b0;
    endtask

    task automatic run_rounds(input int n, input bit rnd_gap);
        for (int i = 0; i < n; i++) begin
            rk_pulse();
            repeat (rnd_gap ? $urandom_range(0, 4) : 2) @(negedge clk);
        end
    endtask

    task automatic wait_swap(input int target);
        int t = 0;
        while (n_swap < target && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("swap_done", n_swap, target);
        @(negedge clk);
    endtask

    task automatic model_kill();
        model_words     = 0;
        model_full      = 0;
        model_key_valid = 0;
        m_rcnt          = 0;
    endtask

    initial begin
        bus.ld_valid = 1'b0;
        bus.ld_data  = '0;
        bus.rk_req   = 1'b0;
        kill         = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_en_wr", bus.en_wr, 0);
        chk("rst_key_ready", bus.key_ready, 0);
        chk("rst_switch_key", bus.switch_key, 0);
        chk("rst_key_stall", bus.key_stall, 0);
        chk("rst_ld_ready", bus.ld_ready, 0);
        chk("rst_key_valid", key_valid, 0);
        chk("rst_shadow_full", shadow_full, 0);
        chk("rst_sw_err", sw_err, 0);
        @(negedge clk);
        kill = 1'b0;
        #1;
        chk("ld_ready_after_kill", bus.ld_ready, 1);

        // Requests with no active schedule are ignored.
        run_rounds(3, 0);
        chk("rcnt_no_key", dut.rcnt, 0);

        // First schedule, streamed back to back, needs a swap before keys are valid.
        load_words(N_WORDS, 64'h0, 0, 0);
        wait_swap(1);
        chk("switch_count_1", n_switch, 1);

        run_rounds(N_ROUNDS, 0);
        repeat (3) @(negedge clk);
        chk("key_ready_count", n_kr, N_ROUNDS);
        chk("rcnt_block_end", dut.rcnt, 0);

        // Second schedule loaded mid-block; swap must wait for the block to finish.
        run_rounds(5, 0);
        fork
            run_rounds(N_ROUNDS - 5, 0);
            load_words(N_WORDS, 64'h0706050403020100, 1, 20);
        join
        wait_swap(2);
        chk("switch_count_2", n_switch, 2);
        chk("key_ready_count_2", n_kr, 2 * N_ROUNDS);

        // Keyram ignores the first swap pulse: timeout, sticky error, retry.
        stuck = 1;
        load_words(N_WORDS, 64'hdead_beef_0000_0000, 1, 10);
        wait_swap(3);
        chk("switch_count_retry", n_switch, 4);
        chk("sw_err_sticky", sw_err, 1);

        // Kill after ten words discards them; a full schedule is needed again.
        load_words(10, 64'h100, 0, 0);
        kill = 1'b1;
        model_kill();
        repeat (2) @(negedge clk);
        #1;
        chk("kill_sw_err", sw_err, 0);
        chk("kill_key_valid", key_valid, 0);
        chk("kill_en_wr", bus.en_wr, 0);
        @(negedge clk);
        kill = 1'b0;
        load_words(N_WORDS, 64'h200, 0, 30);
        wait_swap(4);
        chk("switch_count_kill", n_switch, 5);

        run_rounds(2 * N_ROUNDS, 1);
        repeat (5) @(negedge clk);
        chk("rcnt_final", dut.rcnt, 0);
        chk("wq_drained", wq.size(), 0);
        chk("kq_drained", kq.size(), 0);
        chk("key_ready_total", n_kr, 4 * N_ROUNDS);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
